// File: rtl/memory_stage_pkg.sv
// Shared types for the memory stage: payload structs, FSM state and access widths.
package memory_stage_pkg;

  // Access width encodings carried in the Execute payload
  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } memoryWidth_;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } memoryState_;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] storeData;
    memoryWidth_ memoryWidth;
    logic        memorySigned;
    logic        memoryReadEnable;
    logic        memoryWriteEnable;
    logic        valid;
    logic        illegal;
  } executeMemoryPayload_;

  typedef struct packed {
    logic stall;
    logic flush;
  } control;

  typedef struct packed {
    logic [31:0] result;
    memoryWidth_ memoryWidth;
    logic        memorySigned;
    logic        memoryReadEnable;
    logic        memoryWriteEnable;
    logic        valid;
    logic        illegal;
  } memoryWritebackPayload_;

  // Natural alignment check: halves need an even address, words a multiple of four.
  // Any width code other than byte/half is handled as a word.
  function automatic logic is_misaligned(input memoryWidth_ width, input logic [1:0] offset);
    case (width)
      MEM_BYTE: is_misaligned = 1'b0;
      MEM_HALF: is_misaligned = offset[0];
      default:  is_misaligned = (offset != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/memory_stage_load_align.sv
// load_align: picks the addressed lane out of a 32-bit read word and extends it.
module load_align
  import memory_stage_pkg::*;
(
  input  logic [31:0] readData,
  input  logic [1:0]  offset,
  input  logic [1:0]  width,
  input  logic        isSigned,
  output logic [31:0] loadData
);

  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  // Select the lane at the byte offset and sign- or zero-extend it
  always_comb begin
    byteLane = readData[8*offset +: 8];
    halfLane = offset[1] ? readData[31:16] : readData[15:0];
    case (width)
      MEM_BYTE: loadData = {{24{isSigned & byteLane[7]}}, byteLane};
      MEM_HALF: loadData = {{16{isSigned & halfLane[15]}}, halfLane};
      default:  loadData = readData;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: issues data-memory accesses for the Execute payload, stalls the
// pipe while a response is outstanding, and registers the result toward Writeback.
// Optional feature: define MEM_MISALIGN_TRAP_EN to turn misaligned half/word
// accesses into illegal, access-free instructions; otherwise the offending low
// address bits are ignored.
module memory_stage
  import memory_stage_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  executeMemoryPayload_   executeMemoryPayload,
  input  control                 memoryWritebackControl,
  output memoryWritebackPayload_ memoryWritebackPayload,
  output logic                   memoryStallRequest,
  output logic                   dmemRequest,
  output logic                   dmemWrite,
  output logic [31:0]            dmemAddress,
  output logic [31:0]            dmemWriteData,
  output logic [3:0]             dmemByteEnable,
  input  logic                   dmemReady,
  input  logic [31:0]            dmemReadData
);

  memoryState_            state_q, state_d;
  logic                   done_q, done_d;
  logic                   kill_q, kill_d;
  logic [31:0]            readBuffer_q, readBuffer_d;
  memoryWritebackPayload_ payload_q, payload_d;

  logic        memoryOp;
  logic        misaligned;
  logic        trapAccess;
  logic        accessWanted;
  logic        issue;
  logic        complete;
  logic        loadEnable;
  logic [1:0]  effOffset;
  logic [31:0] alignSource;
  logic [31:0] loadData;

  // Decode whether the Execute payload wants a bus access and where it lands
  always_comb begin
    memoryOp   = executeMemoryPayload.valid && !executeMemoryPayload.illegal &&
                 (executeMemoryPayload.memoryReadEnable || executeMemoryPayload.memoryWriteEnable);
    misaligned = is_misaligned(executeMemoryPayload.memoryWidth, executeMemoryPayload.result[1:0]);
`ifdef MEM_MISALIGN_TRAP_EN
    trapAccess = memoryOp && misaligned;
`else
    trapAccess = 1'b0;
`endif
    accessWanted = memoryOp && !trapAccess;
    // Offending low bits are dropped so a misaligned access falls back to its natural boundary
    case (executeMemoryPayload.memoryWidth)
      MEM_BYTE: effOffset = executeMemoryPayload.result[1:0];
      MEM_HALF: effOffset = {executeMemoryPayload.result[1], 1'b0};
      default:  effOffset = 2'b00;
    endcase
    // A completed access parked behind a downstream stall must not be re-issued
    issue = accessWanted && (state_q == MEM_IDLE) && !done_q && !reset;
  end

  // Bus address, write data replication and byte enables follow the held payload
  always_comb begin
    dmemAddress = {executeMemoryPayload.result[31:2], 2'b00};
    case (executeMemoryPayload.memoryWidth)
      MEM_BYTE: begin
        dmemWriteData  = {4{executeMemoryPayload.storeData[7:0]}};
        dmemByteEnable = 4'b0001 << effOffset;
      end
      MEM_HALF: begin
        dmemWriteData  = {2{executeMemoryPayload.storeData[15:0]}};
        dmemByteEnable = 4'b0011 << effOffset;
      end
      default: begin
        dmemWriteData  = executeMemoryPayload.storeData;
        dmemByteEnable = 4'b1111;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= MEM_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: wait only when the response is not there in the issue cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      MEM_IDLE: if (issue && !dmemReady) state_d = MEM_WAIT;
      MEM_WAIT: if (dmemReady)           state_d = MEM_IDLE;
      default:                           state_d = MEM_IDLE;
    endcase
  end

  // FSM outputs: request held through WAIT regardless of flush, stall while unanswered
  always_comb begin
    dmemRequest        = !reset && (issue || (state_q == MEM_WAIT));
    dmemWrite          = dmemRequest && executeMemoryPayload.memoryWriteEnable;
    memoryStallRequest = dmemRequest && !dmemReady;
    complete           = dmemRequest && dmemReady;
  end

  // Done flag, flush-kill flag and read buffer bookkeeping
  always_comb begin
    loadEnable = !memoryWritebackControl.flush && !memoryWritebackControl.stall &&
                 !memoryStallRequest;
    // Done lasts from completion until the downstream stall lets the result in
    if (done_q) done_d = memoryWritebackControl.stall;
    else        done_d = complete && memoryWritebackControl.stall;
    // A flush that lands while the instruction is still in this stage must
    // also suppress its eventual valid when it finally loads
    if (loadEnable)
      kill_d = 1'b0;
    else if (memoryWritebackControl.flush &&
             (((state_q == MEM_WAIT) && !dmemReady) || done_d))
      kill_d = 1'b1;
    else
      kill_d = kill_q;
    readBuffer_d = complete ? dmemReadData : readBuffer_q;
    alignSource  = done_q ? readBuffer_q : dmemReadData;
  end

  load_align u_load_align (
    .readData (alignSource),
    .offset   (effOffset),
    .width    (executeMemoryPayload.memoryWidth),
    .isSigned (executeMemoryPayload.memorySigned),
    .loadData (loadData)
  );

  // MEM/WB register next value: flush clears valid, stalls hold, otherwise load
  always_comb begin
    payload_d = payload_q;
    if (memoryWritebackControl.flush) begin
      payload_d.valid = 1'b0;
    end else if (loadEnable) begin
      payload_d.result            = (accessWanted && executeMemoryPayload.memoryReadEnable) ?
                                    loadData : executeMemoryPayload.result;
      payload_d.memoryWidth       = executeMemoryPayload.memoryWidth;
      payload_d.memorySigned      = executeMemoryPayload.memorySigned;
      payload_d.memoryReadEnable  = executeMemoryPayload.memoryReadEnable;
      payload_d.memoryWriteEnable = executeMemoryPayload.memoryWriteEnable;
      payload_d.valid             = executeMemoryPayload.valid && !kill_q;
      payload_d.illegal           = executeMemoryPayload.illegal || trapAccess;
    end
  end

  // Control flops and the MEM/WB register
  always_ff @(posedge clock) begin
    if (reset) begin
      done_q    <= 1'b0;
      kill_q    <= 1'b0;
      payload_q <= '0;
    end else begin
      done_q    <= done_d;
      kill_q    <= kill_d;
      payload_q <= payload_d;
    end
  end

  // Response capture for results that must wait out a downstream stall
  always_ff @(posedge clock) begin
    readBuffer_q <= readBuffer_d;
  end

  assign memoryWritebackPayload = payload_q;

endmodule

// File: tb/tb_memory_stage.sv
// Testbench for memory_stage: directed scenarios plus randomized transactions
// checked against an arithmetic reference model.
module tb_memory_stage;
  import memory_stage_pkg::*;

  logic                   clock = 1'b0;
  logic                   reset;
  executeMemoryPayload_   execP;
  control                 ctl;
  memoryWritebackPayload_ wbP;
  logic                   stallReq;
  logic                   dmemRequest;
  logic                   dmemWrite;
  logic [31:0]            dmemAddress;
  logic [31:0]            dmemWriteData;
  logic [3:0]             dmemByteEnable;
  logic                   dmemReady;
  logic [31:0]            dmemReadData;

  int n_cmp = 0;
  int n_bad = 0;
  memoryWritebackPayload_ last_out;

  always #5 clock = ~clock;

  memory_stage dut (
    .clock                  (clock),
    .reset                  (reset),
    .executeMemoryPayload   (execP),
    .memoryWritebackControl (ctl),
    .memoryWritebackPayload (wbP),
    .memoryStallRequest     (stallReq),
    .dmemRequest            (dmemRequest),
    .dmemWrite              (dmemWrite),
    .dmemAddress            (dmemAddress),
    .dmemWriteData          (dmemWriteData),
    .dmemByteEnable         (dmemByteEnable),
    .dmemReady              (dmemReady),
    .dmemReadData           (dmemReadData)
  );

  typedef struct packed {
    logic                   acc;
    logic [31:0]            addr;
    logic [3:0]             be;
    logic [31:0]            wdata;
    memoryWritebackPayload_ out;
  } exp_t;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour computed from the access rules with plain arithmetic
  function automatic exp_t model(input executeMemoryPayload_ p, input logic [31:0] rdata);
    exp_t        e;
    logic        memop, mis, trap;
    logic [31:0] a, eff, lane, v;
    int          off;
    a     = p.result;
    memop = p.valid && !p.illegal && (p.memoryReadEnable || p.memoryWriteEnable);
    mis   = (p.memoryWidth == MEM_HALF && (a % 2) != 0) ||
            (p.memoryWidth == MEM_WORD && (a % 4) != 0);
`ifdef MEM_MISALIGN_TRAP_EN
    trap = memop && mis;
`else
    trap = 1'b0;
`endif
    e.acc = memop && !trap;
    if (p.memoryWidth == MEM_HALF)      eff = a - (a % 2);
    else if (p.memoryWidth == MEM_WORD) eff = a - (a % 4);
    else                                eff = a;
    off    = int'(eff % 4);
    e.addr = eff - (eff % 4);
    if (p.memoryWidth == MEM_BYTE) begin
      e.be    = 4'(1 << off);
      e.wdata = (p.storeData % 256) * 32'h0101_0101;
      lane    = (rdata >> (8 * off)) % 256;
      v       = (p.memorySigned && lane >= 128) ? lane - 256 : lane;
    end else if (p.memoryWidth == MEM_HALF) begin
      e.be    = 4'(3 << off);
      e.wdata = (p.storeData % 65536) * 32'h0001_0001;
      lane    = (rdata >> (8 * off)) % 65536;
      v       = (p.memorySigned && lane >= 32768) ? lane - 65536 : lane;
    end else begin
      e.be    = 4'hF;
      e.wdata = p.storeData;
      v       = rdata;
    end
    e.out.result            = (e.acc && p.memoryReadEnable) ? v : a;
    e.out.memoryWidth       = p.memoryWidth;
    e.out.memorySigned      = p.memorySigned;
    e.out.memoryReadEnable  = p.memoryReadEnable;
    e.out.memoryWriteEnable = p.memoryWriteEnable;
    e.out.valid             = p.valid;
    e.out.illegal           = p.illegal || trap;
    return e;
  endfunction

  function automatic executeMemoryPayload_ mk(input logic [31:0] addr, input logic [31:0] sd,
                                              input int w, input logic sgn, input logic re,
                                              input logic we, input logic vld, input logic ill);
    executeMemoryPayload_ p;
    p.result            = addr;
    p.storeData         = sd;
    p.memoryWidth       = memoryWidth_'(w);
    p.memorySigned      = sgn;
    p.memoryReadEnable  = re;
    p.memoryWriteEnable = we;
    p.valid             = vld;
    p.illegal           = ill;
    return p;
  endfunction

  // One instruction: lat cycles until dmemReady, then downstream stall held for hold cycles
  task automatic run_txn(input string tag, input executeMemoryPayload_ p, input logic [31:0] rdata,
                         input int lat, input int hold);
    exp_t e;
    int   cycles;
    e      = model(p, rdata);
    cycles = e.acc ? lat : 0;
    execP  = p;
    ctl    = '0;
    for (int c = 0; c <= cycles; c++) begin
      dmemReady    = e.acc ? (c == cycles) : 1'($urandom);
      dmemReadData = (c == cycles) ? rdata : $urandom;
      ctl.stall    = (c == cycles) && (hold > 0);
      #1;
      chk({tag, ".req"},   64'(dmemRequest), 64'(e.acc));
      chk({tag, ".stall"}, 64'(stallReq),    64'(e.acc && (c < cycles)));
      if (e.acc) begin
        chk({tag, ".addr"}, 64'(dmemAddress),    64'(e.addr));
        chk({tag, ".be"},   64'(dmemByteEnable), 64'(e.be));
        chk({tag, ".wr"},   64'(dmemWrite),      64'(p.memoryWriteEnable));
        if (p.memoryWriteEnable) chk({tag, ".wdata"}, 64'(dmemWriteData), 64'(e.wdata));
      end
      @(negedge clock);
      if (c < cycles || hold > 0) chk({tag, ".held"}, 64'(wbP), 64'(last_out));
    end
    for (int h = 1; h <= hold; h++) begin
      ctl.stall    = (h < hold);
      dmemReady    = 1'($urandom);
      dmemReadData = $urandom;
      #1;
      chk({tag, ".noreissue"}, 64'(dmemRequest), 64'(0));
      chk({tag, ".nostall"},   64'(stallReq),    64'(0));
      @(negedge clock);
      if (h < hold) chk({tag, ".held2"}, 64'(wbP), 64'(last_out));
    end
    chk({tag, ".out"}, 64'(wbP), 64'(e.out));
    last_out = e.out;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    exp_t                 e;
    executeMemoryPayload_ p;
    reset        = 1'b1;
    execP        = '0;
    ctl          = '0;
    dmemReady    = 1'b0;
    dmemReadData = '0;
    last_out     = '0;

    // Reset state
    repeat (2) @(negedge clock);
    #1;
    chk("rst.req",   64'(dmemRequest), 64'(0));
    chk("rst.stall", 64'(stallReq),    64'(0));
    chk("rst.out",   64'(wbP),         64'(0));
    @(negedge clock);
    reset = 1'b0;

    // Word store, zero-wait
    run_txn("st_word", mk(32'h1000, 32'hDEADBEEF, 2, 0, 0, 1, 1, 0), 32'h0, 0, 0);
    // Signed byte load, three wait cycles
    run_txn("ld_byte", mk(32'h1003, 32'h0, 0, 1, 1, 0, 1, 0), 32'h80FF_FF00, 3, 0);
    chk("ld_byte.value", 64'(wbP.result), 64'(32'hFFFF_FF80));
    // Unsigned half load in the upper lane
    run_txn("ld_half", mk(32'h2002, 32'h0, 1, 0, 1, 0, 1, 0), 32'h8001_0000, 1, 0);
    chk("ld_half.value", 64'(wbP.result), 64'(32'h0000_8001));
    // Load completing under a downstream stall: buffered data, no second request
    run_txn("ld_hold", mk(32'h2001, 32'h0, 0, 1, 1, 0, 1, 0), 32'h1234_F678, 2, 3);
    // Misaligned word load
    run_txn("ld_mis", mk(32'h1001, 32'h0, 2, 0, 1, 0, 1, 0), 32'hCAFE_F00D, 1, 0);
    // Invalid and illegal payloads issue nothing
    run_txn("invalid", mk(32'h4000, 32'h55, 2, 0, 1, 1, 0, 0), 32'h0, 0, 0);
    run_txn("illegal", mk(32'h4004, 32'h66, 2, 0, 0, 1, 1, 1), 32'h0, 0, 0);

    // Flush while waiting: request persists, result comes out invalid
    p     = mk(32'h3000, 32'h0, 2, 0, 1, 0, 1, 0);
    e     = model(p, 32'hA5A5_5A5A);
    execP = p;
    for (int c = 0; c < 4; c++) begin
      ctl.stall    = 1'b0;
      ctl.flush    = (c == 1);
      dmemReady    = (c == 3);
      dmemReadData = (c == 3) ? 32'hA5A5_5A5A : $urandom;
      #1;
      chk("flush.req",   64'(dmemRequest), 64'(1));
      chk("flush.stall", 64'(stallReq),    64'(c < 3));
      @(negedge clock);
      if (c == 1) chk("flush.cleared", 64'(wbP.valid), 64'(0));
    end
    ctl = '0;
    e.out.valid = 1'b0;
    chk("flush.out", 64'(wbP), 64'(e.out));
    last_out = e.out;
    run_txn("post_flush", mk(32'h3004, 32'h0, 2, 0, 1, 0, 1, 0), 32'h0BAD_CAFE, 0, 0);

    // Reset in the middle of a wait
    execP     = mk(32'h5000, 32'h0, 2, 0, 1, 0, 1, 0);
    dmemReady = 1'b0;
    #1;
    chk("rstwait.req", 64'(dmemRequest), 64'(1));
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    execP = '0;
    #1;
    chk("rstwait.req",   64'(dmemRequest), 64'(0));
    chk("rstwait.stall", 64'(stallReq),    64'(0));
    chk("rstwait.out",   64'(wbP),         64'(0));
    last_out = '0;
    @(negedge clock);

    // Randomized instructions
    for (int i = 0; i < 60; i++) begin
      int   kind;
      logic vld, ill;
      kind = int'($urandom_range(0, 2));
      vld  = ($urandom_range(0, 9) != 0);
      ill  = ($urandom_range(0, 9) == 0);
      p = mk($urandom, $urandom, int'($urandom_range(0, 2)), 1'($urandom),
             kind == 0, kind == 1, vld, ill);
      run_txn("rand", p, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
